// File: rtl/burst_initiator.sv
// rtl/burst_initiator.sv - command-driven master for the burst memory port
module burst_initiator #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 8,
   parameter int RD_LATENCY = 1,
   parameter int LEN_W      = $clog2(BURST_LEN + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
   input  logic [LEN_W-1:0]      i_cmd_len,
   input  logic                  i_cmd_write,
   input  logic                  i_wdata_valid,
   output logic                  o_wdata_ready,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic                  o_rdata_valid,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_done,
   output logic                  o_err,
   output logic                  o_burst_en,
   output logic [ADDR_WIDTH-1:0] o_addr_top,
   output logic                  o_wren,
   output logic                  o_rden,
   output logic [DATA_WIDTH-1:0] o_wr_data,
   input  logic [DATA_WIDTH-1:0] i_rd_data
);

   // The counter serves as fill index, beat index and drain timer, so it
   // must reach whichever of BURST_LEN and RD_LATENCY is larger.
   localparam int CNT_MAX = (BURST_LEN > RD_LATENCY) ? BURST_LEN : RD_LATENCY;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(BURST_LEN);

   typedef enum logic [2:0] {
      S_IDLE, S_WFILL, S_WBURST, S_RBURST, S_RDRAIN, S_GAP
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_live;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_W-1:0]      r_len;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0] r_buf [0:(2**IDX_W)-1];
   logic [RD_LATENCY-1:0] r_rv_pipe;
   logic                  r_rdata_valid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_done;
   logic                  r_err;

   logic                  w_accept;
   logic                  w_len_ok;
   logic                  w_wr_acc;
   logic                  w_last_beat;
   logic                  w_drain_end;
   logic                  w_cnt_inc;
   logic [IDX_W-1:0]      w_idx;

   assign w_accept    = i_cmd_valid & o_cmd_ready;
   assign w_len_ok    = (i_cmd_len != '0) && (i_cmd_len <= MAX_LEN);
   assign w_wr_acc    = i_wdata_valid & o_wdata_ready;
   assign w_last_beat = (r_cnt == (CNT_W'(r_len) - CNT_W'(1)));
   assign w_drain_end = (r_cnt == CNT_W'(RD_LATENCY));
   assign w_idx       = r_cnt[IDX_W-1:0];
   assign w_cnt_inc   = ((r_state == S_WFILL) & w_wr_acc) | (r_state == S_WBURST) |
                        (r_state == S_RBURST) | (r_state == S_RDRAIN);

   // State register; r_live keeps cmd_ready low until reset has been released.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_live  <= 1'b1;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept && w_len_ok) w_next = i_cmd_write ? S_WFILL : S_RBURST;
         S_WFILL:  if (w_wr_acc && w_last_beat) w_next = S_WBURST;
         S_WBURST: if (w_last_beat) w_next = S_GAP;
         S_RBURST: if (w_last_beat) w_next = S_RDRAIN;
         S_RDRAIN: if (w_drain_end) w_next = S_IDLE;
         S_GAP:    w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Handshake and memory-side outputs; burst_en only for multi-beat bursts.
   always_comb begin
      o_cmd_ready   = 1'b0;
      o_wdata_ready = 1'b0;
      o_burst_en    = 1'b0;
      o_wren        = 1'b0;
      o_rden        = 1'b0;
      o_addr_top    = r_addr + ADDR_WIDTH'(r_cnt);
      o_wr_data     = r_buf[w_idx];
      case (r_state)
         S_IDLE:   o_cmd_ready = r_live;
         S_WFILL:  o_wdata_ready = 1'b1;
         S_WBURST: begin
            o_wren     = 1'b1;
            o_burst_en = (r_len > LEN_W'(1));
         end
         S_RBURST: begin
            o_rden     = 1'b1;
            o_burst_en = (r_len > LEN_W'(1));
         end
         default: ;
      endcase
   end

   // Beat/fill/drain counter restarts on every state change.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (w_next != r_state) begin
         r_cnt <= '0;
      end else if (w_cnt_inc) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Command latch and write buffer.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr <= '0;
         r_len  <= '0;
         for (int k = 0; k < 2**IDX_W; k++) r_buf[k] <= '0;
      end else begin
         if (r_state == S_IDLE && w_accept && w_len_ok) begin
            r_addr <= i_cmd_addr;
            r_len  <= i_cmd_len;
         end
         if (r_state == S_WFILL && w_wr_acc) r_buf[w_idx] <= i_wdata;
      end
   end

   // Read-return pipeline: rd_data for a beat is captured RD_LATENCY cycles later.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rv_pipe     <= '0;
         r_rdata_valid <= 1'b0;
         r_rdata       <= '0;
      end else begin
         r_rv_pipe[0] <= o_rden;
         for (int k = 1; k < RD_LATENCY; k++) r_rv_pipe[k] <= r_rv_pipe[k-1];
         r_rdata_valid <= r_rv_pipe[RD_LATENCY-1];
         if (r_rv_pipe[RD_LATENCY-1]) r_rdata <= i_rd_data;
      end
   end

   // Completion and illegal-length pulses, one cycle each.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_done <= (r_state == S_GAP) | ((r_state == S_RDRAIN) & w_drain_end);
         r_err  <= w_accept & ~w_len_ok;
      end
   end

   assign o_rdata_valid = r_rdata_valid;
   assign o_rdata       = r_rdata;
   assign o_done        = r_done;
   assign o_err         = r_err;

endmodule
